// File: rtl/fifo_param_if.sv
// FIFO bus interface: the write side, the read side, the error-clear request,
// and all of the status outputs in one bundle.
// The master modport is the side that uses the FIFO.
// The slave modport is the FIFO itself.
interface fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] wr_data;
    logic              wr_enb;
    logic              rd_enb;
    logic              err_clr;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_almost_full;
    logic              fifo_almost_empty;
    logic              fifo_overrun;
    logic              fifo_underrun;

    modport master (
        output wr_data, wr_enb, rd_enb, err_clr,
        input  rd_data, fifo_count, fifo_full, fifo_empty,
               fifo_almost_full, fifo_almost_empty,
               fifo_overrun, fifo_underrun
    );

    modport slave (
        input  wr_data, wr_enb, rd_enb, err_clr,
        output rd_data, fifo_count, fifo_full, fifo_empty,
               fifo_almost_full, fifo_almost_empty,
               fifo_overrun, fifo_underrun
    );
endinterface

// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO.
// It has registered read data, an occupancy count, registered
// full/empty/almost flags, and sticky overrun/underrun error flags.
// Storage is a plain array written and read on the clock edge, so it maps
// onto block RAM.
module fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic        clk,
    input  logic        rst,
    fifo_param_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

    // Storage array; contents are deliberately never reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              almost_full_q, almost_full_d;
    logic              almost_empty_q, almost_empty_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;

    logic              rd_accept;
    logic              wr_accept;
    logic              wr_reject;
    logic              rd_reject;

    // Accept or reject each request.
    // Only registered status is used, so there is no combinational path from
    // the requests to any output.
    // A write into a full FIFO goes through when a read frees the slot on the
    // same edge.
    // A read from an empty FIFO never goes through, even when a write is
    // arriving on the same edge.
    always_comb begin
        rd_accept = bus.rd_enb && !empty_q;
        wr_accept = bus.wr_enb && (!full_q || rd_accept);
        wr_reject = bus.wr_enb && !wr_accept;
        rd_reject = bus.rd_enb && empty_q;
    end

    // Next pointers, occupancy and flags.
    // The flags come from the next count, so they agree with fifo_count after
    // every edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        full_d         = (count_d == DEPTH_CNT);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_CNT);
        almost_empty_d = (count_d <= AE_CNT);

        // A new error wins over a clear in the same cycle.
        overrun_d = overrun_q;
        if (wr_reject) begin
            overrun_d = 1'b1;
        end else if (bus.err_clr) begin
            overrun_d = 1'b0;
        end

        underrun_d = underrun_q;
        if (rd_reject) begin
            underrun_d = 1'b1;
        end else if (bus.err_clr) begin
            underrun_d = 1'b0;
        end
    end

    // Pointer, count and flag registers.
    // Reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overrun_q      <= overrun_d;
            underrun_q     <= underrun_d;
        end
    end

    // Array write port.
    // On a full FIFO with a read and a write together, the two pointers are
    // equal. The read register below still captures the old word, because
    // both sides use non-blocking updates on the same edge.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    // Registered read port, with the array read taken directly into the
    // output register so it maps onto the RAM's synchronous read.
    // The value is held when there is no accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_accept) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign bus.rd_data           = rd_data_q;
    assign bus.fifo_count        = count_q;
    assign bus.fifo_full         = full_q;
    assign bus.fifo_empty        = empty_q;
    assign bus.fifo_almost_full  = almost_full_q;
    assign bus.fifo_almost_empty = almost_empty_q;
    assign bus.fifo_overrun      = overrun_q;
    assign bus.fifo_underrun     = underrun_q;
endmodule

// File: tb/tb_fifo_param.sv
// Testbench for fifo_param.
// It runs the directed scenarios first, then randomized traffic in fill-heavy,
// balanced and drain-heavy phases.
// Every output is compared each cycle against a queue-based reference model.
module tb_fifo_param;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;

    logic clk = 1'b0;
    logic rst;

    fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_if ();

    fifo_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_rd_data;
    logic              m_over;
    logic              m_under;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d got=0x%0h expected=0x%0h", tag, txn, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, update the model on the edge,
    // then check every output 1ns after the edge.
    task automatic step(input logic r, input logic w, input logic [DATA_W-1:0] d,
                        input logic rd, input logic clr);
        int  sz;
        bit  rd_ok;
        bit  wr_ok;

        rst            = r;
        bus_if.wr_enb  = w;
        bus_if.wr_data = d;
        bus_if.rd_enb  = rd;
        bus_if.err_clr = clr;
        @(posedge clk);

        sz    = m_q.size();
        rd_ok = rd && (sz > 0);
        wr_ok = w && ((sz < DEPTH) || rd_ok);

        if (r) begin
            m_q.delete();
            m_rd_data = '0;
            m_over    = 1'b0;
            m_under   = 1'b0;
        end else begin
            if (rd_ok) m_rd_data = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
            if (w && !wr_ok) m_over = 1'b1;
            else if (clr)    m_over = 1'b0;
            if (rd && !rd_ok) m_under = 1'b1;
            else if (clr)     m_under = 1'b0;
        end

        #1;
        txn++;
        sz = m_q.size();
        check_val("rd_data",      64'(bus_if.rd_data),           64'(m_rd_data));
        check_val("count",        64'(bus_if.fifo_count),        64'(sz));
        check_val("full",         64'(bus_if.fifo_full),         64'(sz == DEPTH));
        check_val("empty",        64'(bus_if.fifo_empty),        64'(sz == 0));
        check_val("almost_full",  64'(bus_if.fifo_almost_full),  64'(sz >= AF_LEVEL));
        check_val("almost_empty", 64'(bus_if.fifo_almost_empty), 64'(sz <= AE_LEVEL));
        check_val("overrun",      64'(bus_if.fifo_overrun),      64'(m_over));
        check_val("underrun",     64'(bus_if.fifo_underrun),     64'(m_under));
        $display("txn %0d rst=%0d wr=%0d d=0x%02h rd=%0d clr=%0d -> count=%0d rd_data=0x%02h ovr=%0d und=%0d",
                 txn, r, w, d, rd, clr, bus_if.fifo_count, bus_if.rd_data,
                 bus_if.fifo_overrun, bus_if.fifo_underrun);
    endtask

    initial begin
        int pw;
        int pr;

        m_rd_data = '0;
        m_over    = 1'b0;
        m_under   = 1'b0;

        // Reset, with writes, reads and err_clr all requested so that reset
        // has to win over them
        step(1, 1, 8'hEE, 1, 1);
        step(1, 0, 8'h00, 0, 0);

        // Single word through an empty FIFO
        step(0, 1, 8'hAA, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check_val("single_word", 64'(bus_if.rd_data), 64'h00000000000000AA);

        // Fill 0x10..0x1F, then one more write into the full FIFO: overrun
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
        step(0, 1, 8'h55, 0, 0);
        step(0, 0, 8'h00, 0, 1);

        // Full with read and write together: oldest word out, count stays full
        step(0, 1, 8'h99, 1, 0);
        check_val("full_rw_oldest", 64'(bus_if.rd_data), 64'h0000000000000010);
        check_val("full_rw_count",  64'(bus_if.fifo_count), 64'(DEPTH));

        // Drain everything; 0x99 comes out last, after the pointers wrap
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, 0);
        check_val("wrap_last", 64'(bus_if.rd_data), 64'h0000000000000099);

        // Empty with read and write together: underrun set, the write is kept
        step(0, 1, 8'h77, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        check_val("underrun_data", 64'(bus_if.rd_data), 64'h0000000000000077);
        step(0, 0, 8'h00, 0, 1);

        // Partial fill, reset while a write is requested, then rewrite
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0, 0);
        step(1, 1, 8'hF0, 0, 0);
        step(0, 1, 8'h3C, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check_val("post_reset_data", 64'(bus_if.rd_data), 64'h000000000000003C);

        // Randomized phases: fill-heavy, balanced, drain-heavy, balanced
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 50; pr = 50; end
                2:       begin pw = 25; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            for (int n = 0; n < 150; n++) begin
                step(($urandom_range(0, 99) < 1),
                     ($urandom_range(0, 99) < pw),
                     8'($urandom),
                     ($urandom_range(0, 99) < pr),
                     ($urandom_range(0, 99) < 6));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: data width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 16: entry count, power of two, legal range 4..1024.
REQ-003 The block SHALL have parameter AF_LEVEL, default 14: almost-full threshold in entries, legal range 1..DEPTH-1.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2: almost-empty threshold in entries, legal range 1..DEPTH-1.
REQ-005 The block SHALL have these ports, one clock, reset synchronous and active-high:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- wr_data  in  DATA_W  write data
- wr_enb  in  1  write request
- rd_enb  in  1  read request
- err_clr  in  1  clears sticky error flags
- rd_data  out  DATA_W  registered read data
- fifo_count  out  log2(DEPTH)+1  current occupancy
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- fifo_almost_full  out  1  count >= AF_LEVEL
- fifo_almost_empty  out  1  count <= AE_LEVEL
- fifo_overrun  out  1  sticky: write rejected
- fifo_underrun  out  1  sticky: read rejected

Function
REQ-006 Storage SHALL be a DEPTH x DATA_W array with log2(DEPTH)-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-007 A write SHALL be accepted when wr_enb=1 and (fifo_full=0 or a read is accepted in the same cycle); an accepted write stores wr_data at wr_ptr and increments wr_ptr.
REQ-008 A read SHALL be accepted when rd_enb=1 and fifo_empty=0; an accepted read loads rd_data from mem[rd_ptr] on the same rising edge and increments rd_ptr (one-cycle latency; rd_data is valid immediately after that edge).
REQ-009 rd_data SHALL hold its last value on any cycle without an accepted read.
REQ-010 fifo_count SHALL change as follows: +1 on write only, -1 on read only, unchanged on both or neither; it SHALL never exceed DEPTH or go below 0.
REQ-011 Full and simultaneous rd_enb/wr_enb: both SHALL be accepted; count stays DEPTH; no overrun.
REQ-012 Empty and simultaneous rd_enb/wr_enb: the write SHALL be accepted; the read SHALL be rejected and fifo_underrun set; count becomes 1.
REQ-013 All status flags SHALL be registered and consistent with fifo_count after each edge, with no combinational path from wr_enb/rd_enb.
REQ-014 fifo_overrun SHALL set on a rejected write (wr_enb=1, full, no accepted read); the array, pointers and count SHALL be unchanged.
REQ-015 fifo_underrun SHALL set on a rejected read (rd_enb=1, empty); pointers, count and rd_data SHALL be unchanged.
REQ-016 err_clr=1 SHALL clear both sticky flags at the next edge; if a new error occurs in the same cycle, set SHALL take priority over clear.

Reset
REQ-017 When rst=1 at a rising edge: pointers=0, fifo_count=0, rd_data=0, fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0, fifo_overrun=0, fifo_underrun=0.
REQ-018 Reset SHALL override any concurrent wr_enb/rd_enb/err_clr; array contents need not be cleared.
REQ-019 Reset asserted mid-operation (partially filled) SHALL discard all contents; the first read after data is rewritten returns the first post-reset write.

Verification
REQ-020 Reset then write 0xAA, then read -> rd_data=0xAA after the read edge, count 0->1->0, empty 1->0->1.
REQ-021 Defaults: write 0x10..0x1F (16 words) -> almost_full sets when count reaches 14, full at 16; read 16 -> data returns 0x10..0x1F in order, almost_empty sets at count 2, empty at 0.
REQ-022 Full, write 0x55 -> overrun=1, count=16, contents intact; err_clr pulse -> overrun=0 next edge.
REQ-023 Empty, rd_enb and wr_enb=0x77 together -> underrun=1, count=1, next read returns 0x77.
REQ-024 Full, simultaneous read and write of 0x99 -> read returns oldest word, count stays 16, 0x99 is returned 16 reads later (wrap-around across pointer 15->0).
REQ-025 Write 5 words, assert rst for one cycle with wr_enb=1 -> count=0, empty=1, flags clear; write 0x3C then read -> rd_data=0x3C.
